midi_msg_serializer: RTL
========================

# midi_msg_serializer

Buffers complete MIDI messages from the MIDI receiver, stamps each with a 16-bit millisecond timestamp and serialises them as a byte stream to the WIZ830MJ network sender. It sits between the MIDI receiver's 24-bit message/ready-pulse output and the sender's byte-wide payload input, and absorbs bursts while the sender is busy with socket traffic.

## Interface
- DEPTH, 16: FIFO entries, power of two, 2..256.
- TICK_DIV, 50000: clk cycles per timestamp tick (1 ms at 50 MHz).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- midi_msg_in  in  24  message: [23:16] status, [15:8] data1, [7:0] data2.
- midi_msg_we  in  1  one-cycle strobe; midi_msg_in valid in the same cycle.
- byte_out  out  8  current stream byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  sender accepts byte_out when byte_valid && byte_ready.
- msg_count  out  $clog2(DEPTH)+1  messages held in the FIFO; excludes the one being sent.
- overflow  out  1  sticky: at least one message dropped.
- drop_count  out  8  dropped messages, saturates at 255.
- stat_clr  in  1  synchronous clear of overflow and drop_count.
- timestamp  out  16  free-running tick counter.

## Operation
- Clock is clk. Reset is asynchronous and active-high on reset.
- Tick prescaler counts 0..TICK_DIV-1. On wrap, timestamp increments modulo 2^16 (0xFFFF -> 0x0000).
- Write: when midi_msg_we is high and the FIFO is not full, store {timestamp, midi_msg_in} (40 bits). timestamp is sampled in the strobe cycle.
- Write when full and no pop in the same cycle: drop the message, set overflow, increment drop_count (hold at 255).
- Write and pop in the same cycle while full: both occur, count unchanged, no drop.
- stat_clr and a drop in the same cycle: the clear wins; overflow=0 and drop_count=0.
- Output FSM:
  - IDLE: when FIFO is not empty, pop the head into a 40-bit holding register, set byte index to 0 and go to SEND.
  - SEND: byte_valid=1. byte_out in order is ts[15:8], ts[7:0], status, data1, data2. The index advances only on handshake.
  - On acceptance of byte 4: if FIFO is not empty, pop the next entry and stay in SEND at index 0 (no bubble). Otherwise go to IDLE.
- byte_out and byte_valid hold stable while byte_valid && !byte_ready.
- The block does not check MIDI content. Any 24-bit value is passed through unchanged.
- Reset mid-stream aborts the partial message. No partial message is resumed after reset.

## Timing
- Reset values:
  - FSM in IDLE.
  - byte_valid=0, byte_out=0x00.
  - msg_count=0, overflow=0, drop_count=0.
  - timestamp=0, prescaler=0.
  - FIFO pointers 0. FIFO memory content is don't-care.
- Latency: strobe in cycle N into an empty FIFO with the FSM in IDLE:
  - msg_count=1 in N+1.
  - Pop at the end of N+1.
  - byte_valid=1 with byte 0 in N+2.
  - msg_count=0 in N+2.
- Throughput: one byte per cycle while byte_ready is held high. Five cycles per message, back-to-back.
- msg_count, overflow and drop_count are registered and update on the cycle after the causing event.
- The first timestamp increment occurs TICK_DIV cycles after reset release.

## Structure
- Shared package midi_pkg:
  - MSG_BYTES=5.
  - MIDI_MSG_W=24, TS_W=16.
  - An entry typedef {ts, status, data1, data2}.
  - A 3-bit byte-index typedef.
  - The FSM state enum (IDLE, SEND).
- Sub-module midi_ts_fifo: a synchronous FIFO, DEPTH x 40 bits, with registered pointers.
  - push, pop, full, empty and count.
  - Simultaneous push/pop is legal when full and when non-empty.
  - Serializer FSM, prescaler and statistics stay in the top module.

## Test plan
- Single message: after reset with TICK_DIV=4, strobe 0x903C64 at cycle 10, byte_ready=1 -> byte_valid from cycle 12. Stream is 0x00,0x02,0x90,0x3C,0x64 (timestamp 2). msg_count returns to 0.
- Backpressure: byte_ready toggles 1,0,0,1 per cycle during a send -> each byte held stable while stalled. No byte is lost or duplicated; all 5 bytes arrive in order.
- Burst and overflow: DEPTH=4, byte_ready=0, 6 strobes -> one message in the holding register and msg_count=4. overflow=1 and drop_count=1. Release byte_ready -> the first 5 messages stream back-to-back with no idle cycle between them.
- Full with simultaneous pop: FIFO full and byte 4 accepted in the same cycle as a strobe -> message accepted, msg_count unchanged, overflow stays 0.
- Saturation and clear: 300 drops -> drop_count=255. stat_clr pulse -> overflow=0 and drop_count=0 next cycle.
- Reset mid-stream: assert reset after byte 2 -> byte_valid=0 immediately and msg_count=0. Stream resumes cleanly with the next new strobe.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared types for the MIDI message serializer: FIFO entry layout, byte index and FSM states.
package midi_pkg;

    localparam int MSG_BYTES  = 5;
    localparam int MIDI_MSG_W = 24;
    localparam int TS_W       = 16;
    localparam int ENTRY_W    = TS_W + MIDI_MSG_W;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [7:0]      status;
        logic [7:0]      data1;
        logic [7:0]      data2;
    } midi_entry_t;

    typedef logic [2:0] byte_idx_t;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(MSG_BYTES - 1);

    // Wire order of a stamped message: timestamp MSB first, then the three MIDI bytes.
    function automatic logic [7:0] entry_byte(input midi_entry_t e, input byte_idx_t idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = e.ts[15:8];
            3'd1:    b = e.ts[7:0];
            3'd2:    b = e.status;
            3'd3:    b = e.data1;
            3'd4:    b = e.data2;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/midi_msg_serializer_if.sv
// Byte-stream valid/ready link from the serializer to the network sender.
interface midi_msg_serializer_if;

    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_out,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_out,
        input  byte_valid,
        output byte_ready
    );

endinterface

// File: rtl/midi_ts_fifo.sv
// Synchronous FIFO of timestamped MIDI entries with registered pointers and occupancy count.
module midi_ts_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  midi_entry_t            din_i,
    input  logic                   pop_i,
    output midi_entry_t            dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    midi_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/midi_msg_serializer.sv
// Timestamps MIDI messages, buffers them in a FIFO and streams each as five bytes to the sender.
module midi_msg_serializer
    import midi_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [23:0]            midi_msg_in,
    input  logic                   midi_msg_we,
    midi_msg_serializer_if.master  bus,
    output logic [$clog2(DEPTH):0] msg_count,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    input  logic                   stat_clr,
    output logic [15:0]            timestamp
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]   presc_q, presc_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            tick;

    ser_state_t      state_q, state_d;
    byte_idx_t       idx_q, idx_d;
    midi_entry_t     hold_q, hold_d;

    logic            ovf_q, ovf_d;
    logic [7:0]      drops_q, drops_d;

    midi_entry_t     fifo_din, fifo_dout;
    logic            fifo_pop, fifo_full, fifo_empty, drop;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = presc_q + 1'b1;
        ts_d    = ts_q;
        if (tick) begin
            presc_d = '0;
            ts_d    = ts_q + 1'b1;
        end
    end

    assign fifo_din = '{ts: ts_q, status: midi_msg_in[23:16],
                        data1: midi_msg_in[15:8], data2: midi_msg_in[7:0]};

    midi_ts_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (midi_msg_we),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (msg_count)
    );

    // A full FIFO still accepts the strobe when the FSM frees a slot in the same cycle.
    assign drop = midi_msg_we && fifo_full && !fifo_pop;

    always_comb begin
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (stat_clr) begin
            ovf_d   = 1'b0;
            drops_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drops_q != 8'hFF) begin
                drops_d = drops_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_dout;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (bus.byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // Chain straight into the next message so the stream has no bubble.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            hold_d   = fifo_dout;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            ts_q    <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else begin
            presc_q <= presc_d;
            ts_q    <= ts_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign bus.byte_valid = (state_q == SEND);
    assign bus.byte_out   = (state_q == SEND) ? entry_byte(hold_q, idx_q) : 8'h00;
    assign overflow       = ovf_q;
    assign drop_count     = drops_q;
    assign timestamp      = ts_q;

endmodule
